// File: rtl/sram_bus_arbiter.sv
// Two-requester arbiter for the shared address-latch + SRAM pin bus.
// Each granted transaction is expanded into the fixed latch/OE/WE strobe sequence.
module sram_bus_arbiter #(
  parameter int unsigned RD_WAIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       r0_req,
  input  logic       r0_we,
  input  logic [7:0] r0_addr,
  input  logic [7:0] r0_wdata,
  output logic [7:0] r0_rdata,
  output logic       r0_done,
  input  logic       r1_req,
  input  logic       r1_we,
  input  logic [7:0] r1_addr,
  input  logic [7:0] r1_wdata,
  output logic [7:0] r1_rdata,
  output logic       r1_done,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic [7:0] bus_oe,
  output logic       latch_le,
  output logic       mem_oe_n,
  output logic       mem_we_n,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LATCH, S_RD_OE, S_WR_DATA, S_WR_PULSE, S_DONE
  } state_e;

  localparam logic [3:0] RD_WAIT_C = RD_WAIT[3:0];

  state_e      state_q, state_d;
  logic        gnt_q, gnt_d;        // 0 = r0, 1 = r1
  logic        last_q, last_d;      // requester served most recently
  logic        we_q, we_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  r0_rdata_q, r0_rdata_d;
  logic [7:0]  r1_rdata_q, r1_rdata_d;
  logic        r0_done_q, r0_done_d;
  logic        r1_done_q, r1_done_d;
  logic [7:0]  bus_out_q, bus_out_d;
  logic        bus_oe_q, bus_oe_d;
  logic        le_q, le_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        busy_q, busy_d;
  logic        pick;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can infer a latch.
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    r0_rdata_d = r0_rdata_q;
    r1_rdata_d = r1_rdata_q;
    pick       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (r0_req || r1_req) begin
          // On contention the requester not served last wins.
          pick    = (r0_req && r1_req) ? ~last_q : r1_req;
          gnt_d   = pick;
          we_d    = pick ? r1_we    : r0_we;
          addr_d  = pick ? r1_addr  : r0_addr;
          wdata_d = pick ? r1_wdata : r0_wdata;
          state_d = S_ADDR;
        end
      end
      S_ADDR:  state_d = S_LATCH;
      S_LATCH: begin
        cnt_d   = 4'd0;
        state_d = we_q ? S_WR_DATA : S_RD_OE;
      end
      S_RD_OE: begin
        if (cnt_q == RD_WAIT_C) begin
          if (gnt_q) r1_rdata_d = bus_in;
          else       r0_rdata_d = bus_in;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_WR_DATA:  state_d = S_WR_PULSE;
      S_WR_PULSE: state_d = S_DONE;
      S_DONE: begin
        last_d  = gnt_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    bus_out_d = 8'h00;
    bus_oe_d  = 1'b0;
    le_d      = 1'b0;
    oe_n_d    = 1'b1;
    we_n_d    = 1'b1;
    case (state_d)
      S_ADDR: begin
        bus_out_d = addr_d;
        bus_oe_d  = 1'b1;
        le_d      = 1'b1;
      end
      S_LATCH: begin
        bus_out_d = addr_d;
        bus_oe_d  = 1'b1;
      end
      S_RD_OE: oe_n_d = 1'b0;
      S_WR_DATA: begin
        bus_out_d = wdata_d;
        bus_oe_d  = 1'b1;
      end
      S_WR_PULSE: begin
        bus_out_d = wdata_d;
        bus_oe_d  = 1'b1;
        we_n_d    = 1'b0;
      end
      S_DONE: begin
        // Write data stays on the bus one more cycle for SRAM hold time.
        if (we_d) begin
          bus_out_d = wdata_d;
          bus_oe_d  = 1'b1;
        end
      end
      default: ;
    endcase

    r0_done_d = (state_d == S_DONE) && !gnt_d;
    r1_done_d = (state_d == S_DONE) &&  gnt_d;
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      cnt_q      <= 4'd0;
      r0_rdata_q <= 8'h00;
      r1_rdata_q <= 8'h00;
      r0_done_q  <= 1'b0;
      r1_done_q  <= 1'b0;
      bus_out_q  <= 8'h00;
      bus_oe_q   <= 1'b0;
      le_q       <= 1'b0;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      r0_rdata_q <= r0_rdata_d;
      r1_rdata_q <= r1_rdata_d;
      r0_done_q  <= r0_done_d;
      r1_done_q  <= r1_done_d;
      bus_out_q  <= bus_out_d;
      bus_oe_q   <= bus_oe_d;
      le_q       <= le_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      busy_q     <= busy_d;
    end
  end

  assign r0_rdata = r0_rdata_q;
  assign r1_rdata = r1_rdata_q;
  assign r0_done  = r0_done_q;
  assign r1_done  = r1_done_q;
  assign bus_out  = bus_out_q;
  assign bus_oe   = {8{bus_oe_q}};
  assign latch_le = le_q;
  assign mem_oe_n = oe_n_q;
  assign mem_we_n = we_n_q;
  assign busy     = busy_q;

endmodule
